// File: rtl/lint_combine_pkg.sv
// Shared types and constants for the lint_combine_pipe datapath.
package lint_combine_pkg;
    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_HOLD = 2'b11
    } combine_mode_e;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;
endpackage

// File: rtl/lint_combine_lane.sv
// Combinational per-lane operator: combines the current beat with the previous one.
module lint_combine_lane
    import lint_combine_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] h,
    input  logic [1:0]       mode,
    input  logic             check,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = '0;
        if (check) begin
            case (combine_mode_e'(mode))
                MODE_AND:  result = d & h;
                MODE_OR:   result = d | h;
                MODE_XOR:  result = d ^ h;
                MODE_HOLD: result = h;
            endcase
        end
    end
endmodule

// File: rtl/lint_combine_pipe.sv
// Multi-lane register-and-combine stage with a 2-entry valid/ready output buffer.
// Define LINT_COMBINE_STATS_EN to build the saturating accepted-beat counter.
module lint_combine_pipe
    import lint_combine_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic                      check,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]          beat_count
);
    localparam int DW = CHANNELS * WIDTH;

    logic [DW-1:0] hist_q, hist_d;
    logic [DW-1:0] buf_q [BUF_DEPTH];
    logic [DW-1:0] buf_d [BUF_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] result;
    logic          accept;
    logic          pop;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        lint_combine_lane #(.WIDTH(WIDTH)) u_lane (
            .d      (in_data[k*WIDTH +: WIDTH]),
            .h      (hist_q[k*WIDTH +: WIDTH]),
            .mode   (mode[2*k +: 2]),
            .check  (check),
            .result (result[k*WIDTH +: WIDTH])
        );
    end

    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_q[rd_ptr_q];

    always_comb begin
        hist_d   = hist_q;
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (accept) begin
            buf_d[wr_ptr_q] = result;
            wr_ptr_d        = ~wr_ptr_q;
            hist_d          = in_data;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Registered from next occupancy so in_ready never depends on out_ready.
        in_ready_d = (occ_d < 2'(BUF_DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q     <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            hist_q     <= hist_d;
            buf_q      <= buf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef LINT_COMBINE_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_count = cnt_q;
`else
    assign beat_count = '0;
`endif
endmodule

// File: tb/tb_lint_combine_pipe.sv
// Randomized and directed bench for lint_combine_pipe against a queue-based reference model.
module tb_lint_combine_pipe;
    localparam int W  = 4;
    localparam int CH = 2;
    localparam int DW = W * CH;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic [2*CH-1:0]   mode = '0;
    logic              check = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [15:0]       beat_count;

    lint_combine_pipe #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode       (mode),
        .check      (check),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_hist = '0;
    logic [15:0]   m_cnt = '0;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_combine(input logic [DW-1:0] d, input logic [DW-1:0] h,
                                                     input logic [2*CH-1:0] m, input logic ck);
        logic [DW-1:0] r;
        logic [W-1:0]  dk, hk, rk;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            dk = d[k*W +: W];
            hk = h[k*W +: W];
            case (m[2*k +: 2])
                2'd0:    rk = dk & hk;
                2'd1:    rk = dk | hk;
                2'd2:    rk = dk ^ hk;
                default: rk = hk;
            endcase
            r[k*W +: W] = ck ? rk : '0;
        end
        return r;
    endfunction

    task automatic check_outputs();
        expect_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        expect_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() != 0) expect_eq("out_data", 32'(out_data), 32'(mq[0]));
        expect_eq("beat_count", 32'(beat_count), 32'(m_cnt));
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [2*CH-1:0] m,
                        input logic ck, input logic ordy);
        logic          acc, pp;
        logic [DW-1:0] tmp;
        in_valid  = iv;
        in_data   = d;
        mode      = m;
        check     = ck;
        out_ready = ordy;
        acc = iv && (mq.size() < 2);
        pp  = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (pp) tmp = mq.pop_front();
        if (acc) begin
            mq.push_back(model_combine(d, m_hist, m, ck));
            m_hist = d;
`ifdef LINT_COMBINE_STATS_EN
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        end
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        mq.delete();
        m_hist = '0;
        m_cnt  = '0;
    endtask

    logic [3:0] mode_tab [4];

    initial begin
        mode_tab = '{4'h8, 4'hE, 4'h6, 4'hC};

        // Reset held with in_valid high
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
        expect_eq("rst_in_ready", 32'(in_ready), 32'd1);
        expect_eq("rst_out_data", 32'(out_data), 32'd0);
        expect_eq("rst_beat_count", 32'(beat_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        step(1'b1, 8'hFF, 4'b0101, 1'b1, 1'b1);
        expect_eq("first_beat", 32'(out_data), 32'h0FF);

        for (int md = 0; md < 4; md++) begin
            step(1'b1, 8'h0C, {2'(md), 2'(md)}, 1'b1, 1'b1);
            step(1'b1, 8'h0A, {2'(md), 2'(md)}, 1'b1, 1'b1);
            expect_eq($sformatf("mode_tab%0d", md), 32'(out_data[3:0]), 32'(mode_tab[md]));
        end

        step(1'b1, 8'h0C, 4'b0101, 1'b1, 1'b1);
        step(1'b1, 8'h0A, 4'b0101, 1'b0, 1'b1);
        expect_eq("check_zero", 32'(out_data), 32'h0);
        step(1'b1, 8'h03, 4'b0101, 1'b1, 1'b1);
        expect_eq("hist_after_check0", 32'(out_data[3:0]), 32'hB);

        step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);

        // Backpressure: four cycles stalled, two accepts
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 * (i + 1)), 4'b0101, 1'b1, 1'b0);
        expect_eq("bp_in_ready", 32'(in_ready), 32'd0);
        expect_eq("bp_out_valid", 32'(out_valid), 32'd1);
        step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);
        expect_eq("bp_drained_in_ready", 32'(in_ready), 32'd1);

        // Full buffer with pop and in_valid together
        step(1'b1, 8'h5A, 4'b1010, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 4'b1010, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 4'b1010, 1'b1, 1'b1);
        expect_eq("fullpop_out_valid", 32'(out_valid), 32'd1);
        expect_eq("fullpop_in_ready", 32'(in_ready), 32'd1);
        step(1'b1, 8'h3C, 4'b1010, 1'b1, 1'b0);
        expect_eq("fullpop_next_accept", 32'(in_ready), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with two entries buffered
        step(1'b1, 8'h77, 4'b0101, 1'b1, 1'b0);
        step(1'b1, 8'h66, 4'b0101, 1'b1, 1'b0);
        step(1'b1, 8'h55, 4'b0101, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        expect_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        expect_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
        expect_eq("async_rst_out_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h5C, 4'b1010, 1'b1, 1'b1);
        expect_eq("post_rst_hist0", 32'(out_data), 32'h5C);

        // Long run for counter saturation
        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check     = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
`ifdef LINT_COMBINE_STATS_EN
        expect_eq("beat_count_sat", 32'(beat_count), 32'hFFFF);
`else
        expect_eq("beat_count_tied", 32'(beat_count), 32'h0);
`endif
        expect_eq("long_run_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
